// File: rtl/ipa_cfg_regfile.sv
`default_nettype none
// ============================================================================
// ipa_cfg_regfile : IPA config slave (COMMAND/STATUS/IRQ_EN/GP regs + job FSM)
// Optional watchdog enabled by defining IPA_CFG_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module ipa_cfg_regfile #(
  parameter int DATA_WIDTH     = 32,
  parameter int BE_WIDTH       = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 5,
  parameter int N_GP_REGS      = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_ipa_cfg_req,
  input  logic                            s_ipa_cfg_wen,
  input  logic [ADDR_WIDTH-1:0]           s_ipa_cfg_add,
  input  logic [DATA_WIDTH-1:0]           s_ipa_cfg_wdata,
  input  logic [BE_WIDTH-1:0]             s_ipa_cfg_be,
  input  logic [ID_WIDTH-1:0]             s_ipa_cfg_id,
  output logic                            s_ipa_cfg_gnt,
  output logic [DATA_WIDTH-1:0]           s_ipa_cfg_rdata,
  output logic                            s_ipa_cfg_valid,
  output logic [ID_WIDTH-1:0]             s_ipa_cfg_r_id,
  input  logic                            ipa_exec_complete,
  output logic                            ipa_start,
  output logic                            ipa_busy,
  output logic                            ipa_irq,
  output logic [N_GP_REGS*DATA_WIDTH-1:0] cfg_regs
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_e;

  localparam logic [5:0] REG_CMD    = 6'd0;
  localparam logic [5:0] REG_STATUS = 6'd1;
  localparam logic [5:0] REG_IRQ_EN = 6'd2;
  localparam int         GP_BASE    = 4;
  localparam int         B_DONE     = 0;
  localparam int         B_BUSY     = 1;
  localparam int         B_ERR      = 2;
  localparam int         B_TMO      = 3;
  localparam logic [3:0] W1C_MASK   = 4'b1101;

  state_e                          state_q, state_d;
  logic [DATA_WIDTH-1:1]           cmd_q, cmd_d;
  logic [3:0]                      status_q, status_d;
  logic [3:0]                      irq_en_q, irq_en_d;
  logic [N_GP_REGS*DATA_WIDTH-1:0] gp_q, gp_d;
  logic [DATA_WIDTH-1:0]           rdata_q, rdata_d;
  logic                            valid_q;
  logic [ID_WIDTH-1:0]             r_id_q;
  logic                            start_q, start_d;
  logic                            irq_q, irq_d;

  logic [5:0]            idx;
  logic                  wr, rd, start_wr, tmo_hit;
  logic [DATA_WIDTH-1:0] be_mask;
  logic                  unused_add;

  assign idx        = s_ipa_cfg_add[7:2];
  assign wr         = s_ipa_cfg_req & ~s_ipa_cfg_wen;
  assign rd         = s_ipa_cfg_req &  s_ipa_cfg_wen;
  assign start_wr   = wr & (idx == REG_CMD) & s_ipa_cfg_be[0] & s_ipa_cfg_wdata[0];
  assign unused_add = ^{s_ipa_cfg_add[ADDR_WIDTH-1:8], s_ipa_cfg_add[1:0]};

  always_comb begin
    be_mask = '0;
    for (int b = 0; b < BE_WIDTH; b++) begin
      be_mask[b*8 +: 8] = {8{s_ipa_cfg_be[b]}};
    end
  end

`ifdef IPA_CFG_TIMEOUT_EN
  localparam int         CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [3:0] IRQ_EN_MASK = 4'hF;
  logic [CNT_W-1:0] tmo_cnt_q;

  // Counts completed RUN cycles; the limit is reached on the TIMEOUT_CYCLES-th one.
  assign tmo_hit = (state_q == RUN) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q == START) begin
      tmo_cnt_q <= '0;
    end else if (state_q == RUN) begin
      tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
    end
  end
`else
  localparam logic [3:0] IRQ_EN_MASK = 4'h7;
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      if (idx == REG_CMD) begin
        rdata_d = {cmd_q, 1'b0};
      end else if (idx == REG_STATUS) begin
        rdata_d[3:0] = status_q;
      end else if (idx == REG_IRQ_EN) begin
        rdata_d[3:0] = irq_en_q;
      end else begin
        for (int k = 0; k < N_GP_REGS; k++) begin
          if (idx == 6'(GP_BASE + k)) rdata_d = gp_q[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_comb begin
    cmd_d    = cmd_q;
    irq_en_d = irq_en_q;
    gp_d     = gp_q;
    status_d = status_q;
    state_d  = state_q;
    start_d  = 1'b0;

    if (wr) begin
      if (idx == REG_CMD) begin
        cmd_d = (cmd_q & ~be_mask[DATA_WIDTH-1:1]) | (s_ipa_cfg_wdata[DATA_WIDTH-1:1] & be_mask[DATA_WIDTH-1:1]);
      end
      if (idx == REG_IRQ_EN) begin
        irq_en_d = ((irq_en_q & ~be_mask[3:0]) | (s_ipa_cfg_wdata[3:0] & be_mask[3:0])) & IRQ_EN_MASK;
      end
      if (idx == REG_STATUS && s_ipa_cfg_be[0]) begin
        status_d = status_q & ~(s_ipa_cfg_wdata[3:0] & W1C_MASK);
      end
      for (int k = 0; k < N_GP_REGS; k++) begin
        if (idx == 6'(GP_BASE + k)) begin
          gp_d[k*DATA_WIDTH +: DATA_WIDTH] = (gp_q[k*DATA_WIDTH +: DATA_WIDTH] & ~be_mask)
                                           | (s_ipa_cfg_wdata & be_mask);
        end
      end
    end

    // Hardware status updates come after W1C so a same-cycle set wins.
    case (state_q)
      IDLE: begin
        if (start_wr) begin
          state_d          = START;
          start_d          = 1'b1;
          status_d[B_BUSY] = 1'b1;
        end
      end
      START: state_d = RUN;
      RUN: begin
        if (ipa_exec_complete) begin
          status_d[B_DONE] = 1'b1;
          status_d[B_BUSY] = 1'b0;
          state_d          = IDLE;
        end else if (tmo_hit) begin
          status_d[B_TMO]  = 1'b1;
          status_d[B_BUSY] = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_wr && state_q != IDLE) status_d[B_ERR] = 1'b1;

    irq_d = |(status_d & irq_en_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      status_q <= '0;
      irq_en_q <= '0;
      gp_q     <= '0;
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      r_id_q   <= '0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      status_q <= status_d;
      irq_en_q <= irq_en_d;
      gp_q     <= gp_d;
      rdata_q  <= rdata_d;
      valid_q  <= s_ipa_cfg_req;
      if (s_ipa_cfg_req) r_id_q <= s_ipa_cfg_id;
      start_q  <= start_d;
      irq_q    <= irq_d;
    end
  end

  assign s_ipa_cfg_gnt   = 1'b1;
  assign s_ipa_cfg_rdata = rdata_q;
  assign s_ipa_cfg_valid = valid_q;
  assign s_ipa_cfg_r_id  = r_id_q;
  assign ipa_start       = start_q;
  assign ipa_busy        = status_q[B_BUSY];
  assign ipa_irq         = irq_q;
  assign cfg_regs        = gp_q;

endmodule
`default_nettype wire

// File: tb/tb_ipa_cfg_regfile.sv
`default_nettype none
// Bench for ipa_cfg_regfile: directed and random bus/job traffic against a
// behavioural register/job model; responses checked through a scoreboard queue.
module tb_ipa_cfg_regfile;
  localparam int N   = 8;
  localparam int TMO = 16;
`ifdef IPA_CFG_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0, wen = 1'b0, cmp = 1'b0;
  logic [31:0]   add = '0, wdata = '0;
  logic [3:0]    be = '0;
  logic [4:0]    id = '0;
  logic          gnt, valid, ipa_start, ipa_busy, ipa_irq;
  logic [31:0]   rdata;
  logic [4:0]    r_id;
  logic [N*32-1:0] cfg_regs;

  always #5 clk = ~clk;

  ipa_cfg_regfile #(
    .DATA_WIDTH(32), .BE_WIDTH(4), .ADDR_WIDTH(32), .ID_WIDTH(5),
    .N_GP_REGS(N), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_ipa_cfg_req(req), .s_ipa_cfg_wen(wen), .s_ipa_cfg_add(add),
    .s_ipa_cfg_wdata(wdata), .s_ipa_cfg_be(be), .s_ipa_cfg_id(id),
    .s_ipa_cfg_gnt(gnt), .s_ipa_cfg_rdata(rdata), .s_ipa_cfg_valid(valid),
    .s_ipa_cfg_r_id(r_id), .ipa_exec_complete(cmp), .ipa_start(ipa_start),
    .ipa_busy(ipa_busy), .ipa_irq(ipa_irq), .cfg_regs(cfg_regs)
  );

  typedef struct packed { logic [4:0] rid; logic [31:0] data; } rsp_t;
  rsp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_cmd, last_rd;
  logic [31:0] m_gp [N];
  logic [3:0]  m_ien;
  bit          m_done, m_busy, m_err, m_tmo, m_pulse;
  int          m_run;
  bit          exp_start, exp_busy, exp_irq;

  function automatic void chk(string nm, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_cmd = '0; last_rd = '0; m_ien = '0;
    for (int k = 0; k < N; k++) m_gp[k] = '0;
    m_done = 0; m_busy = 0; m_err = 0; m_tmo = 0; m_pulse = 0; m_run = 0;
    exp_start = 0; exp_busy = 0; exp_irq = 0;
    exp_q.delete();
  endtask

  // One bus cycle seen by the model: predict the response, then apply effects.
  task automatic model_step(input bit rq, input bit wn, input logic [31:0] ad, input logic [31:0] wd,
                            input logic [3:0] b, input logic [4:0] tid, input bit c);
    int w;
    logic [31:0] rv, mk;
    bit wr, st_wr, c_eff, t_eff, was_busy, was_pulse;
    w  = int'(ad[7:2]);
    rv = '0;
    if (w == 0)                   rv = {m_cmd[31:1], 1'b0};
    else if (w == 1)              rv = {28'd0, m_tmo, m_err, m_busy, m_done};
    else if (w == 2)              rv = {28'd0, m_ien};
    else if (w >= 4 && w - 4 < N) rv = m_gp[w-4];
    if (rq) begin
      if (wn) last_rd = rv;
      exp_q.push_back('{rid: tid, data: last_rd});
    end
    mk        = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    wr        = rq && !wn;
    was_busy  = m_busy;
    was_pulse = m_pulse;
    st_wr     = wr && w == 0 && b[0] && wd[0];
    c_eff     = c && was_busy && !was_pulse;
    t_eff     = TMO_ON && was_busy && !was_pulse && !c_eff && (m_run + 1 == TMO);
    if (wr) begin
      if (w == 0) m_cmd = (m_cmd & ~mk) | (wd & mk);
      else if (w == 1 && b[0]) begin
        if (wd[0]) m_done = 0;
        if (wd[2]) m_err  = 0;
        if (wd[3]) m_tmo  = 0;
      end
      else if (w == 2) m_ien = 4'(((32'(m_ien) & ~mk) | (wd & mk)) & (TMO_ON ? 32'hF : 32'h7));
      else if (w >= 4 && w - 4 < N) m_gp[w-4] = (m_gp[w-4] & ~mk) | (wd & mk);
    end
    if (st_wr) begin
      if (was_busy) m_err = 1;
      else          m_busy = 1;
    end
    if (c_eff) begin m_done = 1; m_busy = 0; end
    if (t_eff) begin m_tmo  = 1; m_busy = 0; end
    m_run     = was_pulse ? 0 : (was_busy ? m_run + 1 : m_run);
    m_pulse   = st_wr && !was_busy;
    exp_start = m_pulse;
    exp_busy  = m_busy;
    exp_irq   = |({m_tmo, m_err, m_busy, m_done} & m_ien);
  endtask

  task automatic cyc(input bit rq, input bit wn, input logic [31:0] ad, input logic [31:0] wd,
                     input logic [3:0] b, input logic [4:0] tid, input bit c);
    @(negedge clk);
    req = rq; wen = wn; add = ad; wdata = wd; be = b; id = tid; cmp = c;
    model_step(rq, wn, ad, wd, b, tid, c);
  endtask

  task automatic rd_reg(input logic [31:0] ad, input logic [4:0] tid);
    cyc(1, 1, ad, $urandom(), $urandom(), tid, 0);
  endtask

  task automatic wr_reg(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] b, input logic [4:0] tid, input bit c);
    cyc(1, 0, ad, wd, b, tid, c);
  endtask

  task automatic idle(input int n, input bit c);
    for (int i = 0; i < n; i++) cyc(0, 1, '0, '0, '0, '0, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    req = 0; wen = 0; add = '0; wdata = '0; be = '0; id = '0; cmp = 0;
    model_reset();
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_r_id", r_id, 0);
    chk("rst_start", ipa_start, 0);
    chk("rst_busy", ipa_busy, 0);
    chk("rst_irq", ipa_irq, 0);
    chk("rst_cfg_regs", cfg_regs, 0);
    chk("gnt", gnt, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected response must be presented on every cycle after a request.
  rsp_t            mon_e;
  logic [N*32-1:0] mon_flat;
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("valid", valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        if (valid) begin
          chk("r_id", r_id, mon_e.rid);
          chk("rdata", rdata, mon_e.data);
        end
      end
      chk("ipa_start", ipa_start, exp_start);
      chk("ipa_busy", ipa_busy, exp_busy);
      chk("ipa_irq", ipa_irq, exp_irq);
      for (int k = 0; k < N; k++) mon_flat[k*32 +: 32] = m_gp[k];
      chk("cfg_regs", cfg_regs, mon_flat);
    end
  end

  logic [31:0] r_ad, r_wd;
  int          r_sel;
  bit          r_rq, r_wn, r_c;
  initial begin
    model_reset();
    do_reset();
    idle(1, 0);

    rd_reg(32'h00, 3); rd_reg(32'h04, 3); rd_reg(32'h08, 3); rd_reg(32'h10, 3);
    idle(1, 0);

    wr_reg(32'h18, 32'hAABBCCDD, 4'b0101, 1, 0);
    idle(1, 0);
    chk("gp2_bytes", cfg_regs[95:64], 32'h00BB00DD);
    rd_reg(32'h18, 2);

    wr_reg(32'h08, 32'h1, 4'hF, 4, 0);
    wr_reg(32'h00, 32'h1, 4'hF, 5, 0);
    idle(9, 0);
    idle(1, 1);
    idle(1, 0);
    chk("irq_on_done", ipa_irq, 1);
    rd_reg(32'h04, 6);
    wr_reg(32'h04, 32'h1, 4'hF, 7, 0);
    idle(2, 0);
    chk("irq_cleared", ipa_irq, 0);

    wr_reg(32'h00, 32'h1, 4'hF, 8, 0);
    idle(3, 0);
    wr_reg(32'h00, 32'hF1, 4'hF, 9, 0);
    rd_reg(32'h04, 10);
    rd_reg(32'h00, 11);
    idle(2, 1);

    wr_reg(32'h00, 32'h1, 4'hF, 12, 0);
    idle(3, 0);
    wr_reg(32'h04, 32'h1, 4'h1, 13, 1);
    rd_reg(32'h04, 14);
    idle(1, 0);

`ifdef IPA_CFG_TIMEOUT_EN
    wr_reg(32'h04, 32'hF, 4'hF, 15, 0);
    wr_reg(32'h00, 32'h1, 4'hF, 16, 0);
    idle(TMO + 3, 0);
    rd_reg(32'h04, 17);
    idle(1, 0);
`endif

    wr_reg(32'h00, 32'h1, 4'hF, 18, 0);
    idle(4, 0);
    do_reset();
    idle(2, 0);

    for (int i = 0; i < 800; i++) begin
      r_rq  = ($urandom_range(0, 9) < 6);
      r_wn  = $urandom_range(0, 1) == 1;
      r_c   = ($urandom_range(0, 5) == 0);
      r_sel = $urandom_range(0, N + 4);
      r_ad  = $urandom();
      if (r_sel < 4)       r_ad[7:2] = 6'(r_sel);
      else if (r_sel < N + 4) r_ad[7:2] = 6'(r_sel);
      else                 r_ad[7:2] = 6'($urandom_range(0, 63));
      r_wd  = $urandom();
      cyc(r_rq, r_wn, r_ad, r_wd, 4'($urandom()), 5'($urandom()), r_c);
    end

    idle(3, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
